// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, instruction kinds,
// forced funct3 values, immediate range limits and the queued-word record.
// Optional build macro: ENCODER_ROUNDTRIP_CHECK_EN (adds the roundtrip flag).
package instruction_encoder_pkg;

    typedef enum logic [1:0] {
        TIPO_R   = 2'd0,
        TIPO_LD  = 2'd1,
        TIPO_SD  = 2'd2,
        TIPO_BEQ = 2'd3
    } tipo_e;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_LD    = 7'b0000011;
    localparam logic [6:0] OPCODE_SD    = 7'b0100011;
    localparam logic [6:0] OPCODE_BEQ   = 7'b1100011;

    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_SD  = 3'b011;
    localparam logic [2:0] FUNCT3_BEQ = 3'b000;

    // Signed immediate limits: 12-bit I/S immediates and the 13-bit branch offset.
    localparam longint IMM12_MIN  = -2048;
    localparam longint IMM12_MAX  = 2047;
    localparam longint IMM_BR_MIN = -4096;
    localparam longint IMM_BR_MAX = 4094;

    // One queued output word with the flags that travel alongside it.
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
`ifdef ENCODER_ROUNDTRIP_CHECK_EN
        logic        mismatch;
`endif
    } fifo_entry_t;

    function automatic logic imm_in_range(input logic signed [63:0] value,
                                          input longint lo,
                                          input longint hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Input and output valid/ready streams of the instruction encoder.
// With ENCODER_ROUNDTRIP_CHECK_EN defined the bus also carries roundtrip_mismatch.
interface instruction_encoder_if #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_tipo;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [63:0]          in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef ENCODER_ROUNDTRIP_CHECK_EN
    logic                 roundtrip_mismatch;
`endif

    // Program source side: supplies fields, consumes encoded words.
    modport master (
        output in_valid, in_tipo, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
`ifdef ENCODER_ROUNDTRIP_CHECK_EN
        , input roundtrip_mismatch
`endif
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_tipo, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_count
`ifdef ENCODER_ROUNDTRIP_CHECK_EN
        , output roundtrip_mismatch
`endif
    );
endinterface

// File: rtl/instruction_encoder_pack.sv
// Combinational field packer: builds the RV64I word for one request and flags
// an immediate that does not fit (or an odd branch offset). Low bits are still packed.
module instruction_pack
    import instruction_encoder_pkg::*;
(
    input  tipo_e              tipo_i,
    input  logic [4:0]         rd_i,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic [2:0]         funct3_i,
    input  logic [6:0]         funct7_i,
    input  logic signed [63:0] imm_i,
    output logic [31:0]        instr_o,
    output logic               err_o
);

    // Pack fields according to the instruction kind and range-check the immediate.
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        instr_o = '0;
        err_o   = 1'b0;
        case (tipo_i)
            TIPO_R: begin
                instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPCODE_RTYPE};
            end
            TIPO_LD: begin
                instr_o = {imm_i[11:0], rs1_i, FUNCT3_LD, rd_i, OPCODE_LD};
                err_o   = !imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            TIPO_SD: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, FUNCT3_SD, imm_i[4:0], OPCODE_SD};
                err_o   = !imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            TIPO_BEQ: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, FUNCT3_BEQ,
                           imm_i[4:1], imm_i[11], OPCODE_BEQ};
                err_o   = !imm_in_range(imm_i, IMM_BR_MIN, IMM_BR_MAX) || imm_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Instruction encoder top: packs each accepted request into a 2-entry output
// FIFO, tags words with a running byte address and counts flagged words.
// Optional build macro: ENCODER_ROUNDTRIP_CHECK_EN re-extracts the immediate.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       ERR_CNT_W = 8
) (
    input logic                   clock,
    input logic                   reset,
    instruction_encoder_if.slave  bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]           state_q, state_d;
    fifo_entry_t          slot0_q, slot0_d;   // head of the FIFO, drives the outputs
    fifo_entry_t          slot1_q, slot1_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    fifo_entry_t new_entry;
    tipo_e       in_tipo_e;
    logic [31:0] pack_instr;
    logic        pack_err;
    logic        push;
    logic        pop;

    assign in_tipo_e = tipo_e'(bus.in_tipo);

    instruction_pack u_pack (
        .tipo_i   (in_tipo_e),
        .rd_i     (bus.in_rd),
        .rs1_i    (bus.in_rs1),
        .rs2_i    (bus.in_rs2),
        .funct3_i (bus.in_funct3),
        .funct7_i (bus.in_funct7),
        .imm_i    ($signed(bus.in_imm)),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

`ifdef ENCODER_ROUNDTRIP_CHECK_EN
    logic signed [63:0] rt_extracted, rt_expected;

    // Recover the immediate as the datapath would and compare with the request.
    always_comb begin
        rt_expected  = $signed(bus.in_imm);
        rt_extracted = rt_expected;
        case (in_tipo_e)
            TIPO_LD:  rt_extracted = {{52{pack_instr[31]}}, pack_instr[31:20]};
            TIPO_SD:  rt_extracted = {{52{pack_instr[31]}}, pack_instr[31:25], pack_instr[11:7]};
            TIPO_BEQ: begin
                rt_extracted = {{52{pack_instr[31]}}, pack_instr[31], pack_instr[7],
                                pack_instr[30:25], pack_instr[11:8]};
                rt_expected  = $signed(bus.in_imm) >>> 1;
            end
            default: ;
        endcase
    end
`endif

    // Assemble the record that is written into the FIFO on a push.
    always_comb begin
        new_entry       = '0;
        new_entry.instr = pack_instr;
        new_entry.err   = pack_err;
`ifdef ENCODER_ROUNDTRIP_CHECK_EN
        new_entry.mismatch = !pack_err && (rt_extracted != rt_expected);
`endif
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready  = (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_instr = slot0_q.instr;
    assign bus.out_err   = slot0_q.err;
    assign bus.out_addr  = addr_q;
    assign bus.err_count = err_cnt_q;
`ifdef ENCODER_ROUNDTRIP_CHECK_EN
    assign bus.roundtrip_mismatch = slot0_q.mismatch;
`endif

    // Occupancy FSM and slot movement; a simultaneous push/pop at one entry replaces the head.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    slot0_d = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    slot0_d = new_entry;
                end else if (push) begin
                    slot1_d = new_entry;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Address advances and the saturating error counter accumulate on each pop.
    always_comb begin
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        if (pop) begin
            addr_d = addr_q + ADDR_W'(4);
            if (slot0_q.err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            // NOTE: the FIFO slots are reset because the head slot drives out_instr/out_err, which must read 0 after reset.
            slot0_q   <= '0;
            slot1_q   <= '0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
